skid_buffer: RTL and testbench

//  - Two-entry, fully registered valid/ready pipeline slice; the handshake-driven counterpart to plain enable flops.
//  - Upstream producer drives s_*; downstream consumer drives m_ready. s_ready, m_valid and m_data are all registered.
//  - Breaks combinational timing paths on data, valid and ready. Sustains one transfer per clk.
//  - Inserted between pipeline stages and at block boundaries.

---
 rtl/skid_buffer.sv | 98 +++++++++
 tb/tb_skid_buffer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/skid_buffer.sv
// Two-entry registered valid/ready pipeline slice (main + skid register).
// Optional synchronous flush input enabled by defining SKID_BUFFER_FLUSH_EN.
module skid_buffer #(
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
`ifdef SKID_BUFFER_FLUSH_EN
  input  logic              flush,
`endif
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DWIDTH-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DWIDTH-1:0] m_data
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DWIDTH-1:0]   main_q, main_d;
  logic [DWIDTH-1:0]   skid_q, skid_d;
  logic                s_ready_q, s_ready_d;
  logic                m_valid_q, m_valid_d;
  logic                xfer_in, xfer_out;

  // Handshakes use the registered flags so no input reaches an output combinationally.
  assign xfer_in  = s_valid & s_ready_q;
  assign xfer_out = m_valid_q & m_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (xfer_in) begin
          main_d  = s_data;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (xfer_in && xfer_out) begin
          main_d = s_data;
        end else if (xfer_in) begin
          skid_d  = s_data;
          state_d = ST_FULL;
        end else if (xfer_out) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (xfer_out) begin
          main_d  = skid_q;
          state_d = ST_BUSY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
`ifdef SKID_BUFFER_FLUSH_EN
    // Flush wins over any handshake; data regs keep their stale contents.
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
`endif
    s_ready_d = (state_d != ST_FULL);
    m_valid_d = (state_d != ST_EMPTY);
  end

  // s_ready resets low and first rises on the edge after rst is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      main_q    <= main_d;
      skid_q    <= skid_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_data  = main_q;

endmodule

// File: tb/tb_skid_buffer.sv
// Scoreboard bench for skid_buffer: driver pushes expected words, a negedge monitor pops/compares.
// Flush scenario is built only when SKID_BUFFER_FLUSH_EN is defined.
module tb_skid_buffer;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush_tb = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;

  int            vectors = 0;
  int            miscompares = 0;
  logic [DW-1:0] exp_q[$];
  bit            mon_en = 1'b0;
  int            held = 0;
  bit            stall_prev = 1'b0;
  logic [DW-1:0] prev_data = '0;
  bit            rnd_done = 1'b0;

  always #5 clk = ~clk;

  skid_buffer #(.DWIDTH(DW)) dut (
    .clk     (clk),
    .rst     (rst),
`ifdef SKID_BUFFER_FLUSH_EN
    .flush   (flush_tb),
`endif
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: handshakes seen at negedge complete on the following rising edge.
  always @(negedge clk) begin
    if (rst || !mon_en) begin
      held       = 0;
      stall_prev = 1'b0;
    end else begin
      chk("m_valid_vs_held", {63'd0, m_valid}, {63'd0, held != 0});
      chk("s_ready_vs_held", {63'd0, s_ready}, {63'd0, held != 2});
      if (stall_prev) begin
        chk("stall_valid", {63'd0, m_valid}, 64'd1);
        chk("stall_data", 64'(m_data), 64'(prev_data));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 64'(m_data), 64'hDEAD_BEEF);
        end else begin
          chk("out_data", 64'(m_data), 64'(exp_q.pop_front()));
        end
      end
      if (flush_tb) begin
        held       = 0;
        stall_prev = 1'b0;
      end else begin
        held       = held + int'(s_valid && s_ready) - int'(m_valid && m_ready);
        stall_prev = m_valid && !m_ready;
      end
      prev_data = m_data;
    end
  end

  task automatic wait_accept(output int cycles);
    bit acc;
    cycles = 0;
    forever begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      cycles++;
      if (acc) break;
      if (cycles > 1000) begin
        chk("accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
  endtask

  task automatic send(input logic [DW-1:0] d, output int cycles);
    exp_q.push_back(d);
    s_valid = 1'b1;
    s_data  = d;
    wait_accept(cycles);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    while ((exp_q.size() != 0 || m_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(nm, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rel_first_cycle_s_ready", {63'd0, s_ready}, 64'd0);
    @(posedge clk);
    #1;
    chk("rel_s_ready", {63'd0, s_ready}, 64'd1);
    chk("rel_m_valid", {63'd0, m_valid}, 64'd0);
    chk("rel_m_data", 64'(m_data), 64'd0);
    mon_en = 1'b1;
  endtask

  initial begin
    int cyc;
    int total;

    // Reset state
    #1;
    chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
    chk("rst_s_ready", {63'd0, s_ready}, 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    release_reset();

    // Back-to-back stream with m_ready high
    m_ready = 1'b1;
    total = 0;
    for (int i = 1; i <= 8; i++) begin
      send(DW'(i), cyc);
      total += cyc;
      chk("stream_latency_valid", {63'd0, m_valid}, 64'd1);
      chk("stream_latency_data", 64'(m_data), 64'(i));
      chk("stream_s_ready", {63'd0, s_ready}, 64'd1);
    end
    chk("stream_cycles", 64'(total), 64'd8);
    drain("stream_drain");

    // Backpressure
    m_ready = 1'b0;
    send(8'hA1, cyc);
    chk("bp_a1_data", 64'(m_data), 64'hA1);
    send(8'hA2, cyc);
    chk("bp_full_s_ready", {63'd0, s_ready}, 64'd0);
    chk("bp_hold_a1", 64'(m_data), 64'hA1);
    exp_q.push_back(8'hA3);
    s_valid = 1'b1;
    s_data  = 8'hA3;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("bp_a3_blocked", {63'd0, s_ready}, 64'd0);
      chk("bp_a1_stable", 64'(m_data), 64'hA1);
    end
    m_ready = 1'b1;
    wait_accept(cyc);
    drain("bp_drain");

    // Reset while FULL discards both words
    m_ready = 1'b0;
    send(8'hB1, cyc);
    send(8'hB2, cyc);
    s_valid = 1'b0;
    chk("pre_rst_full", {63'd0, s_ready}, 64'd0);
    #2;
    rst = 1'b1;
    mon_en = 1'b0;
    #1;
    chk("midrst_m_valid", {63'd0, m_valid}, 64'd0);
    chk("midrst_s_ready", {63'd0, s_ready}, 64'd0);
    chk("midrst_m_data", 64'(m_data), 64'd0);
    exp_q.delete();
    release_reset();
    m_ready = 1'b1;
    send(8'h5C, cyc);
    drain("post_rst_drain");

`ifdef SKID_BUFFER_FLUSH_EN
    // Flush from FULL with a coincident input word
    m_ready = 1'b0;
    send(8'hC1, cyc);
    send(8'hC2, cyc);
    exp_q.push_back(8'hC3);
    s_valid  = 1'b1;
    s_data   = 8'hC3;
    flush_tb = 1'b1;
    @(posedge clk);
    #1;
    flush_tb = 1'b0;
    s_valid  = 1'b0;
    exp_q.delete();
    chk("flush_m_valid", {63'd0, m_valid}, 64'd0);
    chk("flush_s_ready", {63'd0, s_ready}, 64'd1);
    m_ready = 1'b1;
    send(8'hD1, cyc);
    drain("flush_drain");
`endif

    // Random valid/ready traffic
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          while ($urandom_range(1) == 0) begin
            s_valid = 1'b0;
            @(posedge clk);
            #1;
          end
          send(DW'($urandom), cyc);
        end
        s_valid  = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          m_ready = ($urandom_range(1) == 1);
          @(posedge clk);
          #1;
        end
      end
    join
    drain("random_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
